bram_delay_sync_track: RTL

// Companion control stage to the BRAM data delay line. Delays the 1-bit frame

---
 rtl/bram_delay_sync_track.sv | 109 ++++++++++
 1 files changed

// File: rtl/bram_delay_sync_track.sv
// bram_delay_sync_track: delays a 1-bit frame sync by DELAY enabled clocks
// using a small timestamp FIFO in place of a DELAY-deep shift register.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   ce        clock enable; all state holds when low
//   sync_in   sync pulse, sampled when ce=1
//   sync_out  sync_in delayed by DELAY enabled clocks (one-clk pulse)
//   primed    high once DELAY enabled clocks have elapsed since reset
//   pending   number of syncs currently in flight
//   overflow  sticky; a sync was dropped because the FIFO was full
module bram_delay_sync_track #(
  parameter  int DELAY       = 1024,
  parameter  int MAX_PENDING = 4,
  localparam int TS_BITS     = $clog2(DELAY) + 1,
  localparam int CW          = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          sync_in,
  output logic          sync_out,
  output logic          primed,
  output logic [CW-1:0] pending,
  output logic          overflow
);

  localparam int PW =
    (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;

  localparam logic [TS_BITS-1:0] LAST =
    TS_BITS'(DELAY - 1);
  localparam logic [PW-1:0] PTR_END =
    PW'(MAX_PENDING - 1);
  localparam logic [CW-1:0] CNT_FULL =
    CW'(MAX_PENDING);

  logic [TS_BITS-1:0] ts;
  logic [TS_BITS-1:0] fill;
  logic [TS_BITS-1:0] age;
  logic [TS_BITS-1:0] mem [MAX_PENDING];
  logic [PW-1:0]      rd;
  logic [PW-1:0]      wr;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PTR_END) ? '0 : p + 1'b1;
  endfunction

  // Only the head needs inspecting: entries are in push order, so the
  // head is always the oldest. The modular age makes ts wrap harmless
  // because no entry ever lives longer than DELAY enabled clocks.
  always_comb begin
    empty = (pending == '0);
    full  = (pending == CNT_FULL);
    age   = ts - mem[rd];
    pop   = ce && !empty && (age == LAST);
    // A pop in the same cycle frees the slot the push is about to use.
    push  = ce && sync_in && (!full || pop);
    drop  = ce && sync_in && full && !pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts       <= '0;
      rd       <= '0;
      wr       <= '0;
      pending  <= '0;
      sync_out <= 1'b0;
      overflow <= 1'b0;
      fill     <= '0;
      primed   <= 1'b0;
    end else begin
      // Not gated by ce: the pulse lasts one clk even if ce drops.
      sync_out <= pop;
      if (ce) ts <= ts + 1'b1;
      if (push) wr <= nxt(wr);
      if (pop) rd <= nxt(rd);
      unique case ({push, pop})
        2'b10:   pending <= pending + CW'(1);
        2'b01:   pending <= pending - CW'(1);
        default: pending <= pending;
      endcase
      if (drop) overflow <= 1'b1;
      if (ce && !primed) begin
        fill <= fill + 1'b1;
        if (fill == LAST) primed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_PENDING; i++)
        mem[i] <= '0;
    end else if (push) begin
      mem[wr] <= ts;
    end
  end

endmodule
